// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the datamem arbiter.
//   arb_state_e      : arbiter FSM states
//   arb_port_e       : requester identity (instruction / data)
//   LINE_OFFSET_MASK : byte-offset bits inside a 16-byte line, cleared on grant
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_e;

  localparam logic [31:0] LINE_OFFSET_MASK = 32'h0000_000F;

endpackage : mem_arb_pkg

// File: rtl/rr_picker2.sv
// ---------------------------------------------------------------------------
// rr_picker2
// Combinational two-way requester selection.
//   i_req[0]     in  instruction port requesting
//   i_req[1]     in  data port requesting
//   i_last_grant in  port granted most recently
//   o_valid      out at least one port requesting
//   o_grant      out selected port (meaningful only with o_valid)
// On contention: ROUND_ROBIN=1 picks the port that did not win last time,
// ROUND_ROBIN=0 always picks the data port.
// ---------------------------------------------------------------------------
module rr_picker2
  import mem_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic [1:0] i_req,
  input  arb_port_e  i_last_grant,
  output logic       o_valid,
  output arb_port_e  o_grant
);

  always_comb begin
    o_valid = |i_req;
    o_grant = PORT_D;
    case (i_req)
      2'b01: o_grant = PORT_I;
      2'b10: o_grant = PORT_D;
      2'b11: begin
        if (ROUND_ROBIN != 0) begin
          o_grant = (i_last_grant == PORT_D) ? PORT_I : PORT_D;
        end else begin
          o_grant = PORT_D;
        end
      end
      default: o_grant = PORT_D;
    endcase
  end

endmodule : rr_picker2

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one line-wide datamem port between the instruction refill path and
// the data cache. One transaction at a time; responses routed back with a
// one-cycle ready pulse.
//   clk, rst                 : clock, asynchronous active-low reset
//   i_req/i_addr             : instruction line read request
//   i_ready/i_readdata       : instruction completion pulse / read line
//   d_req/d_we/d_addr/d_wdata: data request and payload
//   d_ready/d_readdata       : data completion pulse / read line
//   mem_req, WriteEnable,
//   memory_address,
//   mem_writedata            : registered datamem request outputs
//   mem_readdata, mem_ready  : datamem response
//   timeout_err              : sticky, transaction exceeded TIMEOUT cycles
//   i_grant_cnt, d_grant_cnt : wrapping per-port grant counters
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic [LINE_WIDTH-1:0] i_readdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic [LINE_WIDTH-1:0] d_readdata,
  output logic                  mem_req,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [LINE_WIDTH-1:0] mem_writedata,
  input  logic [LINE_WIDTH-1:0] mem_readdata,
  input  logic                  mem_ready,
  output logic                  timeout_err,
  output logic [15:0]           i_grant_cnt,
  output logic [15:0]           d_grant_cnt
);

  // Counter only needs to reach TIMEOUT, where it saturates.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_OFFSET_MASK);

  arb_state_e            r_state;
  arb_port_e             r_grant_q;
  arb_port_e             r_last_grant;
  logic [CW-1:0]         r_busy_cnt;
  logic                  r_mem_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_timeout;
  logic [15:0]           r_i_cnt;
  logic [15:0]           r_d_cnt;

  logic                  w_pick_valid;
  arb_port_e             w_pick;

  rr_picker2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_picker (
    .i_req        ({d_req, i_req}),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_grant      (w_pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant_q    <= PORT_I;
      r_last_grant <= PORT_D;  // first contended grant goes to instruction
      r_busy_cnt   <= '0;
      r_mem_req    <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_timeout    <= 1'b0;
      r_i_cnt      <= '0;
      r_d_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_state      <= BUSY;
            r_mem_req    <= 1'b1;
            r_grant_q    <= w_pick;
            r_last_grant <= w_pick;
            r_busy_cnt   <= '0;
            if (w_pick == PORT_D) begin
              r_addr  <= d_addr & ALIGN_MASK;
              r_wdata <= d_wdata;
              r_we    <= d_we;
              r_d_cnt <= r_d_cnt + 16'd1;
            end else begin
              r_addr  <= i_addr & ALIGN_MASK;
              r_wdata <= '0;
              r_we    <= 1'b0;
              r_i_cnt <= r_i_cnt + 16'd1;
            end
          end
        end
        BUSY: begin
          if (r_busy_cnt != CW'(TIMEOUT)) begin
            r_busy_cnt <= r_busy_cnt + CW'(1);
          end
          // Count becomes TIMEOUT at this edge: flag it now, transaction continues.
          if (r_busy_cnt >= CW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
          end
          if (mem_ready) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_we      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Ready is combinational from mem_ready so the requester sees it in the
  // same cycle as the memory completes.
  assign i_ready        = (r_state == BUSY) && mem_ready && (r_grant_q == PORT_I);
  assign d_ready        = (r_state == BUSY) && mem_ready && (r_grant_q == PORT_D);
  assign i_readdata     = mem_readdata;
  assign d_readdata     = mem_readdata;
  assign mem_req        = r_mem_req;
  assign WriteEnable    = r_we;
  assign memory_address = r_addr;
  assign mem_writedata  = r_wdata;
  assign timeout_err    = r_timeout;
  assign i_grant_cnt    = r_i_cnt;
  assign d_grant_cnt    = r_d_cnt;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [127:0] d_wdata;
  logic [127:0] mem_readdata;
  logic         mem_ready;

  // dut_a: round robin, long timeout
  logic         a_i_ready, a_d_ready, a_mem_req, a_we, a_timeout;
  logic [127:0] a_i_rdata, a_d_rdata, a_wdata;
  logic [31:0]  a_addr;
  logic [15:0]  a_i_cnt, a_d_cnt;

  // dut_b: data always wins, TIMEOUT=4
  logic         b_i_ready, b_d_ready, b_mem_req, b_we, b_timeout;
  logic [127:0] b_i_rdata, b_d_rdata, b_wdata;
  logic [31:0]  b_addr;
  logic [15:0]  b_i_cnt, b_d_cnt;

  mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .ROUND_ROBIN(1), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(a_i_ready), .i_readdata(a_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(a_d_ready), .d_readdata(a_d_rdata),
    .mem_req(a_mem_req), .WriteEnable(a_we), .memory_address(a_addr),
    .mem_writedata(a_wdata), .mem_readdata(mem_readdata), .mem_ready(mem_ready),
    .timeout_err(a_timeout), .i_grant_cnt(a_i_cnt), .d_grant_cnt(a_d_cnt)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .ROUND_ROBIN(0), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(b_i_ready), .i_readdata(b_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(b_d_ready), .d_readdata(b_d_rdata),
    .mem_req(b_mem_req), .WriteEnable(b_we), .memory_address(b_addr),
    .mem_writedata(b_wdata), .mem_readdata(mem_readdata), .mem_ready(mem_ready),
    .timeout_err(b_timeout), .i_grant_cnt(b_i_cnt), .d_grant_cnt(b_d_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    i_req        = 1'b0;
    i_addr       = '0;
    d_req        = 1'b0;
    d_we         = 1'b0;
    d_addr       = '0;
    d_wdata      = '0;
    mem_readdata = '0;
    mem_ready    = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [127:0] wline;
  logic [127:0] rline;
  logic         exp_i;

  initial begin
    wline = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    rline = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // ---------------- reset state
    do_reset();
    chk("rst_mem_req", a_mem_req, 1'b0);
    chk("rst_we", a_we, 1'b0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_wdata", a_wdata, 128'h0);
    chk("rst_cnts", {a_i_cnt, a_d_cnt}, 32'h0);
    chk("rst_timeout", a_timeout, 1'b0);

    // ---------------- single instruction read, ready in 3rd BUSY cycle
    i_req  = 1'b1;
    i_addr = 32'h0000_1234;
    tick();
    chk("ird_mem_req", a_mem_req, 1'b1);
    chk("ird_addr", a_addr, 32'h0000_1230);
    chk("ird_we", a_we, 1'b0);
    chk("ird_wdata", a_wdata, 128'h0);
    chk("ird_icnt", a_i_cnt, 16'd1);
    chk("ird_noready1", a_i_ready, 1'b0);
    tick();
    chk("ird_noready2", a_i_ready, 1'b0);
    tick();
    mem_readdata = rline;
    mem_ready    = 1'b1;
    #1;
    chk("ird_i_ready", a_i_ready, 1'b1);
    chk("ird_d_ready", a_d_ready, 1'b0);
    chk("ird_rdata", a_i_rdata, rline);
    $display("txn ird addr=%0h rdata=%0h", a_addr, a_i_rdata);
    tick();
    i_req     = 1'b0;
    mem_ready = 1'b0;
    chk("ird_mem_req_drop", a_mem_req, 1'b0);
    chk("ird_ready_once", a_i_ready, 1'b0);

    // ---------------- single data write, with payload change mid-BUSY
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0040;
    d_wdata = wline;
    tick();
    chk("dwr_mem_req", a_mem_req, 1'b1);
    chk("dwr_we", a_we, 1'b1);
    chk("dwr_addr", a_addr, 32'h0000_0040);
    chk("dwr_wdata", a_wdata, wline);
    chk("dwr_dcnt", a_d_cnt, 16'd1);
    d_we    = 1'b0;
    d_addr  = 32'h0000_0777;
    d_wdata = rline;
    i_req   = 1'b1;
    tick();
    chk("busy_hold_we", a_we, 1'b1);
    chk("busy_hold_addr", a_addr, 32'h0000_0040);
    chk("busy_hold_wdata", a_wdata, wline);
    chk("busy_hold_icnt", a_i_cnt, 16'd1);
    mem_ready = 1'b1;
    #1;
    chk("dwr_d_ready", a_d_ready, 1'b1);
    chk("dwr_i_ready", a_i_ready, 1'b0);
    $display("txn dwr addr=%0h wdata=%0h", a_addr, a_wdata);
    tick();
    d_req     = 1'b0;
    i_req     = 1'b0;
    mem_ready = 1'b0;
    chk("dwr_mem_req_drop", a_mem_req, 1'b0);
    chk("dwr_we_drop", a_we, 1'b0);

    // ---------------- stray mem_ready while IDLE
    mem_ready = 1'b1;
    #1;
    chk("stray_i_ready", a_i_ready, 1'b0);
    chk("stray_d_ready", a_d_ready, 1'b0);
    tick();
    mem_ready = 1'b0;
    chk("stray_mem_req", a_mem_req, 1'b0);
    chk("stray_cnts", {a_i_cnt, a_d_cnt}, {16'd1, 16'd1});

    // ---------------- continuous contention, zero-latency memory
    do_reset();
    i_req        = 1'b1;
    i_addr       = 32'h0000_0100;
    d_req        = 1'b1;
    d_we         = 1'b0;
    d_addr       = 32'h0000_0205;
    mem_readdata = rline;
    mem_ready    = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_i = ((n % 2) == 0);
      tick();
      chk("cont_mem_req_on", a_mem_req, 1'b1);
      chk("cont_i_ready", a_i_ready, exp_i);
      chk("cont_d_ready", a_d_ready, !exp_i);
      chk("cont_addr", a_addr, exp_i ? 32'h0000_0100 : 32'h0000_0200);
      chk("fixed_d_ready", b_d_ready, 1'b1);
      chk("fixed_i_ready", b_i_ready, 1'b0);
      $display("txn cont n=%0d rr_i=%0b rr_d=%0b fixed_d=%0b", n, a_i_ready, a_d_ready, b_d_ready);
      tick();
      chk("cont_mem_req_gap", a_mem_req, 1'b0);
      chk("cont_gap_ready", {a_i_ready, a_d_ready}, 2'b00);
      chk("fixed_gap", b_mem_req, 1'b0);
    end
    chk("cont_icnt", a_i_cnt, 16'd2);
    chk("cont_dcnt", a_d_cnt, 16'd2);
    chk("fixed_icnt", b_i_cnt, 16'd0);
    chk("fixed_dcnt", b_d_cnt, 16'd4);

    // ---------------- timeout with memory never ready, then async reset
    do_reset();
    d_req = 1'b1;
    tick();
    chk("to_mem_req", b_mem_req, 1'b1);
    chk("to_initial", b_timeout, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("to_before", b_timeout, 1'b0);
    end
    tick();
    chk("to_set", b_timeout, 1'b1);
    chk("to_still_busy", b_mem_req, 1'b1);
    tick();
    tick();
    chk("to_sticky", b_timeout, 1'b1);
    chk("to_long_timeout_clear", a_timeout, 1'b0);
    $display("txn timeout timeout_err=%0b", b_timeout);
    rst = 1'b0;
    #1;
    chk("arst_mem_req", b_mem_req, 1'b0);
    chk("arst_timeout", b_timeout, 1'b0);
    chk("arst_cnts", {b_i_cnt, b_d_cnt}, 32'h0);
    chk("arst_mem_req_a", a_mem_req, 1'b0);
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single line-wide data-memory port (`datamem`) between the instruction-side cache refill path and the data cache. It latches one requester's transaction, sequences the `mem_req`/`mem_ready` handshake to memory, routes the response back, and enforces round-robin fairness on contention. It sits between the two cache miss engines and `datamem` in `top`. It also keeps a timeout flag and grant counters for debug.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `LINE_WIDTH`, 128, memory line width in bits
- `ROUND_ROBIN`, 1, 1 = alternate on contention; 0 = data port always wins
- `TIMEOUT`, 255, BUSY cycles without `mem_ready` before `timeout_err` sets
- `clk  in  1  single clock, rising edge`
- `rst  in  1  one clock; reset is asynchronous and active-low`
- `i_req  in  1  instruction-side line read request, level`
- `i_addr  in  ADDR_WIDTH  instruction-side line address`
- `i_ready  out  1  one-cycle pulse: instruction transaction complete`
- `i_readdata  out  LINE_WIDTH  read line, valid when `i_ready``
- `d_req  in  1  data-side request, level`
- `d_we  in  1  data-side write enable`
- `d_addr  in  ADDR_WIDTH  data-side line address`
- `d_wdata  in  LINE_WIDTH  data-side write line`
- `d_ready  out  1  one-cycle pulse: data transaction complete`
- `d_readdata  out  LINE_WIDTH  read line, valid when `d_ready``
- `mem_req  out  1  request to datamem, registered`
- `WriteEnable  out  1  write qualifier to datamem, registered`
- `memory_address  out  ADDR_WIDTH  line address to datamem, bits [3:0] forced 0, registered`
- `mem_writedata  out  LINE_WIDTH  write line to datamem, registered`
- `mem_readdata  in  LINE_WIDTH  line from datamem`
- `mem_ready  in  1  datamem completion pulse`
- `timeout_err  out  1  sticky, set when a transaction exceeds `TIMEOUT``
- `i_grant_cnt`, `d_grant_cnt`  `out  16  wrapping grant counters`

## Operation
- States: IDLE, BUSY.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one of `i_req`/`d_req` is high, grant that port.
  - If both are high and `ROUND_ROBIN`=1, grant the port not in `last_grant`. With `ROUND_ROBIN`=0, grant data.
  - On grant: latch address (low 4 bits cleared), write data, and write enable into the output registers. Instruction grants set `WriteEnable`=0 and `mem_writedata`=0.
  - On grant: set `grant_q`, update `last_grant`, increment that port's grant counter, go to BUSY.
- BUSY:
  - `mem_req`=1 and all memory outputs are held stable.
  - Requester inputs are ignored; changes during BUSY have no effect.
- On `mem_ready` in BUSY:
  - Pulse the granted port's `x_ready` combinationally in the same cycle.
  - `x_readdata` = `mem_readdata` for both ports at all times; it is meaningful only with `x_ready`.
  - Next edge: go to IDLE, clear `mem_req` and `WriteEnable`.
- `mem_ready` while IDLE is ignored; no ready pulse is produced.
- Requester contract:
  - Hold `x_req` and its payload until `x_ready`.
  - Deassert or change the request at the following edge.
  - A `x_req` seen high in IDLE is always a new transaction.
- Timeout:
  - `busy_cnt` clears on entry to BUSY and increments each BUSY cycle, saturating.
  - When it reaches `TIMEOUT`, `timeout_err` sets and stays set until reset. The transaction is not aborted.
- Reset value of all outputs: 0, including `last_grant`=data (so the first contended grant goes to instruction), counters, `timeout_err`, and state=IDLE.
- Asynchronous reset mid-BUSY drops `mem_req` immediately; the in-flight transaction is abandoned and no ready pulse is produced.

## Timing
- Request high in IDLE at cycle t: `mem_req` is high from cycle t+1.
- `mem_ready` at cycle t+k: `x_ready` pulses in cycle t+k, and `mem_req` is low at t+k+1.
- Mandatory one-cycle IDLE gap between transactions. The earliest next `mem_req` is at t+k+2.
- Zero-latency memory (ready in the first BUSY cycle) is legal; the transaction occupies 2 cycles total.
- Fairness: under continuous contention, grants strictly alternate I, D, I, D.

## Structure
- `mem_arb_pkg`: `arb_state_e` {IDLE, BUSY}, `arb_port_e` {PORT_I, PORT_D}, the line-offset mask constant.
- Sub-module `rr_picker2`: combinational 2-way round-robin selection from `req[1:0]`, `last_grant`, and `ROUND_ROBIN`. All state, counters, and registers live in `mem_arbiter`.

## Test plan
- Single instruction read: `i_req`=1, `i_addr`=0x0000_1234, memory ready after 3 cycles.
  - Required: `memory_address`=0x0000_1230 and `WriteEnable`=0.
  - Required: `i_ready` pulses once with `i_readdata`=`mem_readdata`, and `i_grant_cnt`=1.
- Single data write: `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEAD…BEEF.
  - Required: memory outputs show these values from the cycle after the request.
  - Required: `d_ready` pulses on `mem_ready`, and `mem_req` drops the next cycle.
- Continuous contention, both requests held, zero-latency memory:
  - Required: grant order I, D, I, D. Each `mem_req` burst lasts 1 cycle, separated by 1 idle cycle.
  - Required: both counters equal 2 after four transactions.
- `ROUND_ROBIN`=0 with both requests held: data port granted every time, and `i_ready` never pulses.
- Timeout and reset:
  - With `TIMEOUT`=4 and memory never ready, `timeout_err` rises on the 4th BUSY cycle and stays high.
  - Asserting `rst`=0 then clears `mem_req`, `timeout_err`, and the counters asynchronously.
- Corner inputs:
  - Stray `mem_ready` in IDLE: no ready pulse.
  - Payload change during BUSY: memory outputs stay at the latched values.
